// File: rtl/aes_pkg.sv
// Shared AES round definitions: state type, byte helpers and MixColumns on one column.
// Latency: none, pure types and combinational functions.
// Backpressure: not applicable.
package aes_pkg;

    localparam int AES_NB = 4;

    // Four 32-bit columns; each column has row 0 in bits [31:24] and row 3 in bits [7:0].
    typedef logic [AES_NB-1:0][31:0] aes_state_t;

    // Occupancy of the output register plus skid entry.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2] applied to one column.
    function automatic logic [31:0] mixcol_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_mixcol_word.sv
// MixColumns on a single 32-bit state column.
// Latency: combinational, zero cycles.
// Backpressure: none, no storage.
module aes_mixcol_word
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    assign mixed = mixcol_word(col);

endmodule

// File: rtl/aes_shiftmix_stage.sv
// AES round back-end: ShiftRows, MixColumns (skipped on the final round), AddRoundKey, registered.
// Latency: 1 cycle from accept to output valid, identical with or without the skid buffer.
// Backpressure: valid/ready; AES_SHIFTMIX_SKID_EN adds a skid entry so in_ready is registered.
module aes_shiftmix_stage
    import aes_pkg::*;
#(
    parameter int BYTE_W = 8
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col_0,
    input  logic [31:0] in_col_1,
    input  logic [31:0] in_col_2,
    input  logic [31:0] in_col_3,
    input  logic [31:0] in_rkey_0,
    input  logic [31:0] in_rkey_1,
    input  logic [31:0] in_rkey_2,
    input  logic [31:0] in_rkey_3,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col_0,
    output logic [31:0] out_col_1,
    output logic [31:0] out_col_2,
    output logic [31:0] out_col_3,
    output logic        out_last
);

    aes_state_t in_st;
    aes_state_t rkey;
    aes_state_t shifted;
    aes_state_t mixed;
    aes_state_t result;
    aes_state_t out_q;
    logic       out_last_q;
    logic       accept;

    assign in_st = {in_col_3, in_col_2, in_col_1, in_col_0};
    assign rkey  = {in_rkey_3, in_rkey_2, in_rkey_1, in_rkey_0};

    // ShiftRows: row r of column c comes from row r of column (c+r) mod 4.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < AES_NB; c++) begin
            for (int r = 0; r < AES_NB; r++) begin
                shifted[c][31-BYTE_W*r -: BYTE_W] = in_st[(c + r) % AES_NB][31-BYTE_W*r -: BYTE_W];
            end
        end
    end

    for (genvar g = 0; g < AES_NB; g++) begin : g_mix
        aes_mixcol_word u_mixcol (
            .col   (shifted[g]),
            .mixed (mixed[g])
        );
    end

    // AddRoundKey over either the mixed or, on the final round, the shifted state.
    always_comb begin
        result = '0;
        for (int c = 0; c < AES_NB; c++) begin
            result[c] = (in_last ? shifted[c] : mixed[c]) ^ rkey[c];
        end
    end

    assign accept = in_valid && in_ready;

`ifdef AES_SHIFTMIX_SKID_EN
    buf_state_t state;
    buf_state_t state_nxt;
    aes_state_t skid_q;
    logic       skid_last_q;
    logic       deliver;
    logic       load_out;
    logic       load_skid;
    logic       skid_to_out;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (state != BUF_TWO);
    assign out_valid = (state != BUF_EMPTY);
    assign deliver   = out_valid && out_ready;

    // Occupancy register; reset drops both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and which register captures the round result.
    always_comb begin
        state_nxt   = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    state_nxt = BUF_ONE;
                    load_out  = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && deliver) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_nxt = BUF_TWO;
                    load_skid = 1'b1;
                end else if (deliver) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                // No accept is possible here since in_ready is low.
                if (deliver) begin
                    state_nxt   = BUF_ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: begin
                state_nxt = BUF_EMPTY;
            end
        endcase
    end

    // Output and skid data registers; skid holds an already-finished round result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_last_q  <= 1'b0;
            skid_q      <= '0;
            skid_last_q <= 1'b0;
        end else begin
            if (load_out) begin
                out_q      <= result;
                out_last_q <= in_last;
            end else if (skid_to_out) begin
                out_q      <= skid_q;
                out_last_q <= skid_last_q;
            end
            if (load_skid) begin
                skid_q      <= result;
                skid_last_q <= in_last;
            end
        end
    end
`else
    logic out_valid_q;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;

    // Single output register: load on accept, empty on delivery with nothing behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= result;
            out_last_q  <= in_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_col_0 = out_q[0];
    assign out_col_1 = out_q[1];
    assign out_col_2 = out_q[2];
    assign out_col_3 = out_q[3];
    assign out_last  = out_last_q;

endmodule
